// File: rtl/ones_pattern_gen.sv
// Thermometer-code generator: builds a WIDTH-bit word with `count` ones, right-justified, one '1' per clock.
// Optional serial readout of the pattern is enabled by defining ONES_PATTERN_GEN_SERIAL_OUT_EN.
module ones_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] pattern,
  output logic             done,
  output logic             sat,
  output logic             ser_valid,
  output logic             ser_data
);

  localparam logic [CW-1:0] W_CNT = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [CW-1:0]    r_rem, w_rem_next;
  logic [WIDTH-1:0] r_shreg, w_shreg_next;
  logic [WIDTH-1:0] r_pattern, w_pattern_next;
  logic             r_done, w_done_next;
  logic             r_sat, w_sat_next;
  logic             w_sat_req;

  // Counts above WIDTH saturate instead of wrapping.
  assign w_sat_req = (count > W_CNT);

`ifdef ONES_PATTERN_GEN_SERIAL_OUT_EN
  logic [WIDTH-1:0] r_ser_sh, w_ser_sh_next;
  logic [CW-1:0]    r_bit_cnt, w_bit_cnt_next;
  logic             r_ser_valid, w_ser_valid_next;
  logic             r_ser_data, w_ser_data_next;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_FILL;
      S_FILL:
        if (r_rem == '0) begin
`ifdef ONES_PATTERN_GEN_SERIAL_OUT_EN
          w_state_next = S_SHIFT;
`else
          w_state_next = S_DONE;
`endif
        end
`ifdef ONES_PATTERN_GEN_SERIAL_OUT_EN
      S_SHIFT: if (r_bit_cnt == W_CNT) w_state_next = S_DONE;
`endif
      S_DONE:  if (!start) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rem_next     = r_rem;
    w_shreg_next   = r_shreg;
    w_pattern_next = r_pattern;
    w_done_next    = r_done;
    w_sat_next     = r_sat;
`ifdef ONES_PATTERN_GEN_SERIAL_OUT_EN
    w_ser_sh_next    = r_ser_sh;
    w_bit_cnt_next   = r_bit_cnt;
    w_ser_valid_next = r_ser_valid;
    w_ser_data_next  = r_ser_data;
`endif
    case (r_state)
      S_IDLE:
        if (start) begin
          w_rem_next   = w_sat_req ? W_CNT : count;
          w_sat_next   = w_sat_req;
          w_shreg_next = '0;
        end
      S_FILL:
        if (r_rem != '0) begin
          w_shreg_next = {r_shreg[WIDTH-2:0], 1'b1};
          w_rem_next   = r_rem - 1'b1;
        end else begin
`ifdef ONES_PATTERN_GEN_SERIAL_OUT_EN
          // The first serial bit leaves on the FILL exit edge; r_shreg stays intact for pattern.
          w_ser_valid_next = 1'b1;
          w_ser_data_next  = r_shreg[0];
          w_ser_sh_next    = r_shreg >> 1;
          w_bit_cnt_next   = CW'(1);
`else
          w_pattern_next = r_shreg;
          w_done_next    = 1'b1;
`endif
        end
`ifdef ONES_PATTERN_GEN_SERIAL_OUT_EN
      S_SHIFT:
        if (r_bit_cnt != W_CNT) begin
          w_ser_valid_next = 1'b1;
          w_ser_data_next  = r_ser_sh[0];
          w_ser_sh_next    = r_ser_sh >> 1;
          w_bit_cnt_next   = r_bit_cnt + 1'b1;
        end else begin
          w_ser_valid_next = 1'b0;
          w_ser_data_next  = 1'b0;
          w_pattern_next   = r_shreg;
          w_done_next      = 1'b1;
        end
`endif
      S_DONE:  if (!start) w_done_next = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem     <= '0;
      r_shreg   <= '0;
      r_pattern <= '0;
      r_done    <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_rem     <= w_rem_next;
      r_shreg   <= w_shreg_next;
      r_pattern <= w_pattern_next;
      r_done    <= w_done_next;
      r_sat     <= w_sat_next;
    end
  end

`ifdef ONES_PATTERN_GEN_SERIAL_OUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ser_sh    <= '0;
      r_bit_cnt   <= '0;
      r_ser_valid <= 1'b0;
      r_ser_data  <= 1'b0;
    end else begin
      r_ser_sh    <= w_ser_sh_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_ser_valid <= w_ser_valid_next;
      r_ser_data  <= w_ser_data_next;
    end
  end

  assign ser_valid = r_ser_valid;
  assign ser_data  = r_ser_data;
`else
  assign ser_valid = 1'b0;
  assign ser_data  = 1'b0;
`endif

  assign pattern = r_pattern;
  assign done    = r_done;
  assign sat     = r_sat;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed bench for ones_pattern_gen (WIDTH=8): latency, pattern, saturation, hold, reset abort,
// and serial readout when ONES_PATTERN_GEN_SERIAL_OUT_EN is defined.
module tb_ones_pattern_gen;

  localparam int WIDTH = 8;
  localparam int CW    = 4;
`ifdef ONES_PATTERN_GEN_SERIAL_OUT_EN
  localparam bit SER = 1'b1;
`else
  localparam bit SER = 1'b0;
`endif
  localparam int EXTRA = SER ? WIDTH : 0;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pattern;
  logic             done;
  logic             sat;
  logic             ser_valid;
  logic             ser_data;

  int total = 0;
  int bad   = 0;

  ones_pattern_gen #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .count     (count),
    .pattern   (pattern),
    .done      (done),
    .sat       (sat),
    .ser_valid (ser_valid),
    .ser_data  (ser_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pattern"}, 32'(pattern), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_sat"}, 32'(sat), 32'h0);
    chk({tag, "_ser_valid"}, 32'(ser_valid), 32'h0);
    chk({tag, "_ser_data"}, 32'(ser_data), 32'h0);
  endtask

  // Start a run with count n and walk edge by edge until done; start is left high.
  task automatic run_gen(input string tag, input int n, input logic [7:0] exp_pat, input logic exp_sat);
    int ns;
    int lat;
    logic ev;
    logic ed;
    ns  = (n > WIDTH) ? WIDTH : n;
    lat = ns + 1 + EXTRA;
    count = CW'(n);
    start = 1'b1;
    for (int e = 0; e <= lat; e++) begin
      step();
      ev = SER && (e >= ns + 1) && (e <= ns + WIDTH);
      ed = ev && ((e - ns - 1) < ns);
      chk($sformatf("%s_done_e%0d", tag, e), 32'(done), 32'(e == lat));
      chk($sformatf("%s_sv_e%0d", tag, e), 32'(ser_valid), 32'(ev));
      chk($sformatf("%s_sd_e%0d", tag, e), 32'(ser_data), 32'(ed));
    end
    chk({tag, "_pattern"}, 32'(pattern), 32'(exp_pat));
    chk({tag, "_sat"}, 32'(sat), 32'(exp_sat));
    $display("run %s: count=%0d pattern=%02h sat=%0d latency=%0d", tag, n, pattern, sat, lat);
  endtask

  task automatic release_start(input string tag, input logic [7:0] exp_pat, input logic exp_sat);
    start = 1'b0;
    step();
    chk({tag, "_rel_done"}, 32'(done), 32'h0);
    chk({tag, "_rel_pattern"}, 32'(pattern), 32'(exp_pat));
    chk({tag, "_rel_sat"}, 32'(sat), 32'(exp_sat));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    count = '0;
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset_held");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk_all_zero("idle_no_start");

    run_gen("n3", 3, 8'b0000_0111, 1'b0);
    release_start("n3", 8'b0000_0111, 1'b0);

    run_gen("n0", 0, 8'h00, 1'b0);
    release_start("n0", 8'h00, 1'b0);

    run_gen("n8", 8, 8'hFF, 1'b0);
    release_start("n8", 8'hFF, 1'b0);

    run_gen("n5", 5, 8'b0001_1111, 1'b0);
    release_start("n5", 8'b0001_1111, 1'b0);

    // Saturating request, then hold start high in DONE.
    run_gen("n12", 12, 8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold_done_%0d", i), 32'(done), 32'h1);
      chk($sformatf("hold_pattern_%0d", i), 32'(pattern), 32'hFF);
    end
    release_start("n12", 8'hFF, 1'b1);

    run_gen("n15", 15, 8'hFF, 1'b1);
    release_start("n15", 8'hFF, 1'b1);

    // Mid-run abort: reset asserted after edge 3 of a count=6 run.
    count = CW'(6);
    start = 1'b1;
    for (int e = 0; e <= 3; e++) step();
    chk("abort_not_done", 32'(done), 32'h0);
    reset = 1'b0;
    start = 1'b0;
    #1;
    chk_all_zero("abort_async");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk_all_zero("abort_release");
    $display("abort: reset mid-run cleared all outputs");

    run_gen("n2", 2, 8'b0000_0011, 1'b0);
    release_start("n2", 8'b0000_0011, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
